// File: rtl/ex_stage_pkg.sv
// Shared constants and types for the execute stage: ALU/shift/forward/branch
// encodings, the JALR opcode, and the iterative shifter's state type.
package ex_stage_pkg;

  // Width codes: datapath width W = 1 << (XLEN + 4)
  localparam int XLEN_32B = 1;
  localparam int XLEN_64B = 2;

  // ALU control codes
  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SUB  = 3'b001;
  localparam logic [2:0] ALU_AND  = 3'b010;
  localparam logic [2:0] ALU_OR   = 3'b011;
  localparam logic [2:0] ALU_XOR  = 3'b100;
  localparam logic [2:0] ALU_SLT  = 3'b101;
  localparam logic [2:0] ALU_SLTU = 3'b110;
  localparam logic [2:0] ALU_PASS = 3'b111;

  // Shift kinds
  typedef enum logic [1:0] {
    SHIFT_NONE = 2'b00,
    SHIFT_SLL  = 2'b01,
    SHIFT_SRL  = 2'b10,
    SHIFT_SRA  = 2'b11
  } shift_e;

  // Forward select codes (11 behaves as FWD_REG)
  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  // opA source codes (11 behaves as zero)
  localparam logic [1:0] OPA_RS1  = 2'b00;
  localparam logic [1:0] OPA_PC   = 2'b01;
  localparam logic [1:0] OPA_ZERO = 2'b10;

  // Branch conditions carried in funct3
  localparam logic [2:0] BR_EQ  = 3'b000;
  localparam logic [2:0] BR_NE  = 3'b001;
  localparam logic [2:0] BR_LT  = 3'b100;
  localparam logic [2:0] BR_GE  = 3'b101;
  localparam logic [2:0] BR_LTU = 3'b110;
  localparam logic [2:0] BR_GEU = 3'b111;

  localparam logic [6:0] OPCODE_JALR = 7'b1100111;

  // Iterative shifter states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } shift_state_e;

endpackage

// File: rtl/ex_stage_iter_shifter.sv
// Iterative 1-bit-per-cycle shifter used by the execute stage.
//
// Handshake: start is level-sensitive and means "a shift op sits in EX this
// cycle". In IDLE a start with amt==0 is answered combinationally (result =
// opa, busy low). A start with amt!=0 is captured at the clock edge and busy
// stays high from that cycle through the last SHIFT cycle; done is high for
// exactly one cycle (DONE) with result = shifted value, and the producer must
// replace the op on the edge that ends DONE. flush returns to IDLE at the next
// edge and drops any partial result.
module iter_shifter
  import ex_stage_pkg::*;
#(
  parameter  int XLEN = XLEN_64B,
  localparam int W    = 1 << (XLEN + 4),
  localparam int S    = XLEN + 4
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         start,
  input  shift_e       kind,
  input  logic [W-1:0] opa,
  input  logic [S-1:0] amt,
  input  logic         flush,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] result,
  output shift_state_e state_dbg
);

  shift_state_e state_q, state_d;
  logic [W-1:0] acc_q;
  logic [S-1:0] cnt_q;
  shift_e       kind_q;
  logic         launch;

  assign launch    = start && (amt != '0);
  assign state_dbg = state_q;

  // State register
  always_ff @(posedge i_clk) begin
    if (i_rst) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic; flush overrides every transition
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (launch) state_d = ST_SHIFT;
      ST_SHIFT: if (cnt_q == S'(1)) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    if (flush) state_d = ST_IDLE;
  end

  // Operand capture in IDLE, one-bit shift and countdown in SHIFT
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      acc_q  <= '0;
      cnt_q  <= '0;
      kind_q <= SHIFT_NONE;
    end else if (flush) begin
      cnt_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (launch) begin
            acc_q  <= opa;
            cnt_q  <= amt;
            kind_q <= kind;
          end
        end
        ST_SHIFT: begin
          case (kind_q)
            SHIFT_SLL: acc_q <= {acc_q[W-2:0], 1'b0};
            SHIFT_SRL: acc_q <= {1'b0, acc_q[W-1:1]};
            SHIFT_SRA: acc_q <= {acc_q[W-1], acc_q[W-1:1]};
            default:   acc_q <= acc_q;
          endcase
          cnt_q <= cnt_q - S'(1);
        end
        default: ;
      endcase
    end
  end

  // Outputs: busy from current state (plus the launch cycle), result in DONE
  // or as a zero-amount bypass
  always_comb begin
    busy   = (state_q == ST_SHIFT) || ((state_q == ST_IDLE) && launch);
    done   = (state_q == ST_DONE);
    result = done ? acc_q : opa;
  end

endmodule

// File: rtl/ex_stage.sv
// Execute stage: operand forwarding, ALU, branch/jump resolution, redirect
// target, and the iterative shifter whose busy flag stalls IF/ID/ID-EX.
module ex_stage
  import ex_stage_pkg::*;
#(
  parameter  int XLEN = XLEN_64B,
  localparam int W    = 1 << (XLEN + 4),
  localparam int S    = XLEN + 4
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_flush_ex,
  input  logic [W-1:0] i_regs_do1_e,
  input  logic [W-1:0] i_regs_do2_e,
  input  logic [W-1:0] i_pc_e,
  input  logic [W-1:0] i_imm32_e,
  input  logic [2:0]   i_alu_ctl_e,
  input  logic [1:0]   i_alu_src_opa_e,
  input  logic         i_alu_src_opb_e,
  input  logic [1:0]   i_alu_shift_e,
  input  logic         i_jmp_e,
  input  logic         i_branch_e,
  input  logic [2:0]   i_f3_e,
  input  logic [6:0]   i_opcode_e,
  input  logic [1:0]   i_fwd_a_e,
  input  logic [1:0]   i_fwd_b_e,
  input  logic [W-1:0] i_result_w,
  input  logic [W-1:0] i_alu_result_m,
  output logic [W-1:0] o_alu_result_e,
  output logic [W-1:0] o_wr_data_e,
  output logic         o_pc_src_e,
  output logic [W-1:0] o_pc_target_e,
  output logic         o_stall_ex
);

  logic [W-1:0] fa, fb, op_a, op_b, alu_res, sh_res, jalr_sum;
  logic         cond, is_shift, sh_busy, sh_done;
  shift_state_e sh_state;

  // Forwarding muxes for rs1/rs2
  always_comb begin
    case (i_fwd_a_e)
      FWD_WB:  fa = i_result_w;
      FWD_MEM: fa = i_alu_result_m;
      default: fa = i_regs_do1_e;
    endcase
    case (i_fwd_b_e)
      FWD_WB:  fb = i_result_w;
      FWD_MEM: fb = i_alu_result_m;
      default: fb = i_regs_do2_e;
    endcase
  end

  // ALU operand selection
  always_comb begin
    case (i_alu_src_opa_e)
      OPA_RS1: op_a = fa;
      OPA_PC:  op_a = i_pc_e;
      default: op_a = '0;
    endcase
    op_b = i_alu_src_opb_e ? i_imm32_e : fb;
  end

  // Combinational ALU
  always_comb begin
    case (i_alu_ctl_e)
      ALU_ADD:  alu_res = op_a + op_b;
      ALU_SUB:  alu_res = op_a - op_b;
      ALU_AND:  alu_res = op_a & op_b;
      ALU_OR:   alu_res = op_a | op_b;
      ALU_XOR:  alu_res = op_a ^ op_b;
      ALU_SLT:  alu_res = {{(W-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      ALU_SLTU: alu_res = {{(W-1){1'b0}}, (op_a < op_b)};
      default:  alu_res = op_b;
    endcase
  end

  // Branch condition on the forwarded register operands
  always_comb begin
    case (i_f3_e)
      BR_EQ:   cond = (fa == fb);
      BR_NE:   cond = (fa != fb);
      BR_LT:   cond = ($signed(fa) < $signed(fb));
      BR_GE:   cond = ($signed(fa) >= $signed(fb));
      BR_LTU:  cond = (fa < fb);
      BR_GEU:  cond = (fa >= fb);
      default: cond = 1'b0;
    endcase
  end

  assign is_shift = (i_alu_shift_e != 2'b00);

  iter_shifter #(.XLEN(XLEN)) u_shifter (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .start     (is_shift),
    .kind      (shift_e'(i_alu_shift_e)),
    .opa       (op_a),
    .amt       (op_b[S-1:0]),
    .flush     (i_flush_ex),
    .busy      (sh_busy),
    .done      (sh_done),
    .result    (sh_res),
    .state_dbg (sh_state)
  );

  // Result select, redirect resolution and store data
  always_comb begin
    jalr_sum      = fa + i_imm32_e;
    o_stall_ex    = sh_busy;
    o_wr_data_e   = fb;
    o_pc_target_e = (i_opcode_e == OPCODE_JALR) ? (jalr_sum & {{(W-1){1'b1}}, 1'b0})
                                                : (i_pc_e + i_imm32_e);
    o_pc_src_e    = !sh_busy && (i_jmp_e || (i_branch_e && cond));
    if (sh_done || (is_shift && (sh_state == ST_IDLE) && (op_b[S-1:0] == '0)))
      o_alu_result_e = sh_res;
    else
      o_alu_result_e = alu_res;
  end

  // The shifter never reports busy while presenting its result
  assert property (@(posedge i_clk) disable iff (i_rst) (sh_state == ST_DONE) |-> !o_stall_ex);

endmodule
